alu_issue_stage: RTL and testbench

- The ID/EX issue stage is the initiator that drives the ALU.
- It decodes the MIPS opcode/funct into the ALU's aluOp/useSign encoding and selects operands A/B/shamt.
- Operands are forwarded from the EX/MEM and MEM/WB stages.
- All results are registered into the ID/EX pipeline register, with stall and flush control.
- It sits between the register file/decode and the combinational ALU in the pipelined CPU.

---
 rtl/alu_issue_stage.sv | 166 ++++++++++++++++
 tb/tb_alu_issue_stage.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes MIPS ALU instructions, forwards operands from
// EX/MEM and MEM/WB, and registers the ALU controls with stall/flush handling.
module alu_issue_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [5:0]            opcode,
  input  logic [5:0]            funct,
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rt,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic [4:0]            shamt_in,
  input  logic [15:0]           imm16,
  input  logic [XLEN-1:0]       rs_data,
  input  logic [XLEN-1:0]       rt_data,
  input  logic                  exm_regwrite,
  input  logic [REG_ADDR_W-1:0] exm_rd,
  input  logic [XLEN-1:0]       exm_result,
  input  logic                  wb_regwrite,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_result,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  ex_valid,
  output logic [XLEN-1:0]       ex_a,
  output logic [XLEN-1:0]       ex_b,
  output logic [4:0]            ex_shamt,
  output logic [3:0]            ex_aluOp,
  output logic                  ex_useSign,
  output logic                  ex_regwrite,
  output logic [REG_ADDR_W-1:0] ex_dest,
  output logic                  ex_is_branch,
  output logic                  ex_illegal,
  output logic [31:0]           issue_count
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_NOR = 4'd4;
  localparam logic [3:0] OP_SLL = 4'd5;
  localparam logic [3:0] OP_SRL = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;

  logic [XLEN-1:0]       fwd_rs, fwd_rt, imm_sext, imm_zext;
  logic [XLEN-1:0]       dec_a, dec_b;
  logic [4:0]            dec_shamt;
  logic [3:0]            dec_op;
  logic                  dec_sign, dec_regwrite, dec_branch, dec_ok;
  logic [REG_ADDR_W-1:0] dec_dest;

  // EX/MEM is younger than MEM/WB, so it wins when both target the same register.
  always_comb begin
    if (exm_regwrite && exm_rd == rs && rs != '0)     fwd_rs = exm_result;
    else if (wb_regwrite && wb_rd == rs && rs != '0)  fwd_rs = wb_result;
    else                                              fwd_rs = rs_data;
    if (exm_regwrite && exm_rd == rt && rt != '0)     fwd_rt = exm_result;
    else if (wb_regwrite && wb_rd == rt && rt != '0)  fwd_rt = wb_result;
    else                                              fwd_rt = rt_data;
  end

  assign imm_sext = {{(XLEN-16){imm16[15]}}, imm16};
  assign imm_zext = {{(XLEN-16){1'b0}}, imm16};

  always_comb begin
    dec_ok       = 1'b1;
    dec_op       = OP_ADD;
    dec_sign     = 1'b0;
    dec_a        = fwd_rs;
    dec_b        = fwd_rt;
    dec_shamt    = 5'd0;
    dec_regwrite = 1'b1;
    dec_dest     = rt;
    dec_branch   = 1'b0;
    case (opcode)
      6'h00: begin
        dec_dest = rd;
        case (funct)
          6'h20: begin dec_op = OP_ADD; dec_sign = 1'b1; end
          6'h21: dec_op = OP_ADD;
          6'h22: begin dec_op = OP_SUB; dec_sign = 1'b1; end
          6'h23: dec_op = OP_SUB;
          6'h24: dec_op = OP_AND;
          6'h25: dec_op = OP_OR;
          6'h27: dec_op = OP_NOR;
          6'h2A: begin dec_op = OP_SLT; dec_sign = 1'b1; end
          6'h2B: dec_op = OP_SLT;
          6'h00: begin dec_op = OP_SLL; dec_a = fwd_rt; dec_b = '0; dec_shamt = shamt_in; end
          6'h02: begin dec_op = OP_SRL; dec_a = fwd_rt; dec_b = '0; dec_shamt = shamt_in; end
          default: dec_ok = 1'b0;
        endcase
      end
      6'h08: begin dec_op = OP_ADD; dec_sign = 1'b1; dec_b = imm_sext; end
      6'h09: begin dec_op = OP_ADD; dec_b = imm_sext; end
      6'h0C: begin dec_op = OP_AND; dec_b = imm_zext; end
      6'h0D: begin dec_op = OP_OR;  dec_b = imm_zext; end
      6'h0A: begin dec_op = OP_SLT; dec_sign = 1'b1; dec_b = imm_sext; end
      6'h0B: begin dec_op = OP_SLT; dec_b = imm_sext; end
      6'h0F: begin dec_op = OP_SLL; dec_a = imm_zext; dec_b = '0; dec_shamt = 5'd16; end
      6'h04: begin
        dec_op       = OP_SUB;
        dec_regwrite = 1'b0;
        dec_dest     = '0;
        dec_branch   = 1'b1;
      end
      default: dec_ok = 1'b0;
    endcase
    // Illegal encodings still issue, but as an inert ADD of zeros.
    if (!dec_ok) begin
      dec_op       = OP_ADD;
      dec_sign     = 1'b0;
      dec_a        = '0;
      dec_b        = '0;
      dec_shamt    = 5'd0;
      dec_regwrite = 1'b0;
      dec_dest     = '0;
      dec_branch   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      ex_a         <= '0;
      ex_b         <= '0;
      ex_shamt     <= '0;
      ex_aluOp     <= '0;
      ex_useSign   <= 1'b0;
      ex_regwrite  <= 1'b0;
      ex_dest      <= '0;
      ex_is_branch <= 1'b0;
      ex_illegal   <= 1'b0;
      issue_count  <= '0;
    end else if (flush || !stall) begin
      if (flush || !in_valid) begin
        ex_valid     <= 1'b0;
        ex_a         <= '0;
        ex_b         <= '0;
        ex_shamt     <= '0;
        ex_aluOp     <= '0;
        ex_useSign   <= 1'b0;
        ex_regwrite  <= 1'b0;
        ex_dest      <= '0;
        ex_is_branch <= 1'b0;
        ex_illegal   <= 1'b0;
      end else begin
        ex_valid     <= 1'b1;
        ex_a         <= dec_a;
        ex_b         <= dec_b;
        ex_shamt     <= dec_shamt;
        ex_aluOp     <= dec_op;
        ex_useSign   <= dec_sign;
        ex_regwrite  <= dec_regwrite;
        ex_dest      <= dec_dest;
        ex_is_branch <= dec_branch;
        ex_illegal   <= !dec_ok;
        issue_count  <= issue_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios plus randomized
// traffic against a table-driven reference model of the decode rules.
module tb_alu_issue_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic [3:0]  op;
    logic        sign;
    logic        regwrite;
    logic [4:0]  dest;
    logic        br;
    logic        ill;
  } ex_t;

  localparam logic [2:0] K_R3 = 3'd0, K_SH = 3'd1, K_IS = 3'd2, K_IZ = 3'd3, K_LU = 3'd4, K_BQ = 3'd5;

  typedef struct packed {
    logic [5:0] opc;
    logic [5:0] fn;
    logic [3:0] op;
    logic       sign;
    logic [2:0] kind;
  } rule_t;

  rule_t rules [19] = '{
    '{6'h00, 6'h20, 4'd0, 1'b1, K_R3}, '{6'h00, 6'h21, 4'd0, 1'b0, K_R3},
    '{6'h00, 6'h22, 4'd1, 1'b1, K_R3}, '{6'h00, 6'h23, 4'd1, 1'b0, K_R3},
    '{6'h00, 6'h24, 4'd2, 1'b0, K_R3}, '{6'h00, 6'h25, 4'd3, 1'b0, K_R3},
    '{6'h00, 6'h27, 4'd4, 1'b0, K_R3}, '{6'h00, 6'h2A, 4'd7, 1'b1, K_R3},
    '{6'h00, 6'h2B, 4'd7, 1'b0, K_R3}, '{6'h00, 6'h00, 4'd5, 1'b0, K_SH},
    '{6'h00, 6'h02, 4'd6, 1'b0, K_SH}, '{6'h08, 6'h00, 4'd0, 1'b1, K_IS},
    '{6'h09, 6'h00, 4'd0, 1'b0, K_IS}, '{6'h0C, 6'h00, 4'd2, 1'b0, K_IZ},
    '{6'h0D, 6'h00, 4'd3, 1'b0, K_IZ}, '{6'h0A, 6'h00, 4'd7, 1'b1, K_IS},
    '{6'h0B, 6'h00, 4'd7, 1'b0, K_IS}, '{6'h0F, 6'h00, 4'd5, 1'b0, K_LU},
    '{6'h04, 6'h00, 4'd1, 1'b0, K_BQ}
  };

  logic        clk = 1'b0;
  logic        rst, in_valid, exm_regwrite, wb_regwrite, stall, flush;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt_in, exm_rd, wb_rd;
  logic [15:0] imm16;
  logic [31:0] rs_data, rt_data, exm_result, wb_result;
  logic        ex_valid, ex_useSign, ex_regwrite, ex_is_branch, ex_illegal;
  logic [31:0] ex_a, ex_b, issue_count;
  logic [4:0]  ex_shamt, ex_dest;
  logic [3:0]  ex_aluOp;

  ex_t         obs, exp_ex;
  logic [31:0] exp_count;
  int          n_cmp = 0;
  int          n_err = 0;

  assign obs = {ex_valid, ex_a, ex_b, ex_shamt, ex_aluOp, ex_useSign, ex_regwrite,
                ex_dest, ex_is_branch, ex_illegal};

  always #5 clk = ~clk;

  alu_issue_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .opcode(opcode), .funct(funct),
    .rs(rs), .rt(rt), .rd(rd), .shamt_in(shamt_in), .imm16(imm16),
    .rs_data(rs_data), .rt_data(rt_data),
    .exm_regwrite(exm_regwrite), .exm_rd(exm_rd), .exm_result(exm_result),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_result(wb_result),
    .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_shamt(ex_shamt),
    .ex_aluOp(ex_aluOp), .ex_useSign(ex_useSign), .ex_regwrite(ex_regwrite),
    .ex_dest(ex_dest), .ex_is_branch(ex_is_branch), .ex_illegal(ex_illegal),
    .issue_count(issue_count)
  );

  function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] d);
    if (r != 5'd0 && exm_regwrite && exm_rd == r) return exm_result;
    if (r != 5'd0 && wb_regwrite && wb_rd == r) return wb_result;
    return d;
  endfunction

  // Looks the instruction up in the rule table and builds the issued fields.
  function automatic ex_t ref_decode();
    ex_t e;
    logic [31:0] ra, rb, simm, zimm;
    e = '0;
    e.valid = 1'b1;
    ra = fwd(rs, rs_data);
    rb = fwd(rt, rt_data);
    simm = {{16{imm16[15]}}, imm16};
    zimm = {16'h0000, imm16};
    for (int i = 0; i < 19; i++) begin
      if (opcode == rules[i].opc && (opcode != 6'h00 || funct == rules[i].fn)) begin
        e.op = rules[i].op;
        e.sign = rules[i].sign;
        e.regwrite = 1'b1;
        e.dest = (opcode == 6'h00) ? rd : rt;
        case (rules[i].kind)
          K_R3: begin e.a = ra; e.b = rb; end
          K_SH: begin e.a = rb; e.shamt = shamt_in; end
          K_IS: begin e.a = ra; e.b = simm; end
          K_IZ: begin e.a = ra; e.b = zimm; end
          K_LU: begin e.a = zimm; e.shamt = 5'd16; end
          default: begin e.a = ra; e.b = rb; e.regwrite = 1'b0; e.dest = 5'd0; e.br = 1'b1; end
        endcase
        return e;
      end
    end
    e.ill = 1'b1;
    return e;
  endfunction

  task automatic set_instr(input logic [31:0] instr);
    opcode = instr[31:26]; rs = instr[25:21]; rt = instr[20:16]; rd = instr[15:11];
    shamt_in = instr[10:6]; funct = instr[5:0]; imm16 = instr[15:0];
  endtask

  task automatic no_fwd();
    exm_regwrite = 1'b0; exm_rd = 5'd0; exm_result = 32'd0;
    wb_regwrite = 1'b0; wb_rd = 5'd0; wb_result = 32'd0;
  endtask

  // Advances the reference state and the DUT by one clock edge.
  task automatic tick();
    ex_t nxt;
    nxt = exp_ex;
    if (flush) nxt = '0;
    else if (!stall) begin
      if (in_valid) begin nxt = ref_decode(); exp_count = exp_count + 32'd1; end
      else nxt = '0;
    end
    @(posedge clk);
    exp_ex = nxt;
    #1;
  endtask

  task automatic test_reset();
    n_cmp++; if (obs !== '0) begin n_err++; $display("[TB] FAIL reset_outputs: got %h want 0", obs); end
    n_cmp++; if (issue_count !== 32'd0) begin n_err++; $display("[TB] FAIL reset_count: got %0d want 0", issue_count); end
    rst = 1'b0;
    set_instr({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20});
    rs_data = 32'd11; rt_data = 32'd22; in_valid = 1'b1;
    tick();
    n_cmp++; if (obs !== exp_ex) begin n_err++; $display("[TB] FAIL pre_reset_load: got %h want %h", obs, exp_ex); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (obs !== '0) begin n_err++; $display("[TB] FAIL async_reset_outputs: got %h want 0", obs); end
    n_cmp++; if (issue_count !== 32'd0) begin n_err++; $display("[TB] FAIL async_reset_count: got %0d want 0", issue_count); end
    rst = 1'b0; exp_ex = '0; exp_count = 32'd0;
  endtask

  task automatic test_add();
    ex_t want;
    set_instr({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20});
    rs_data = 32'd5; rt_data = 32'd3; in_valid = 1'b1;
    tick();
    want = '{valid:1'b1, a:32'd5, b:32'd3, shamt:5'd0, op:4'd0, sign:1'b1, regwrite:1'b1, dest:5'd3, br:1'b0, ill:1'b0};
    n_cmp++; if (obs !== want) begin n_err++; $display("[TB] FAIL add: got %h want %h", obs, want); end
    n_cmp++; if (issue_count !== 32'd1) begin n_err++; $display("[TB] FAIL add_count: got %0d want 1", issue_count); end
  endtask

  task automatic test_immediates();
    ex_t want;
    rs_data = 32'h100; rt_data = 32'h55;
    set_instr({6'h09, 5'd1, 5'd4, 16'hFFFF});
    tick();
    want = '{valid:1'b1, a:32'h100, b:32'hFFFFFFFF, shamt:5'd0, op:4'd0, sign:1'b0, regwrite:1'b1, dest:5'd4, br:1'b0, ill:1'b0};
    n_cmp++; if (obs !== want) begin n_err++; $display("[TB] FAIL addiu: got %h want %h", obs, want); end
    set_instr({6'h0C, 5'd1, 5'd4, 16'hFFFF});
    tick();
    want = '{valid:1'b1, a:32'h100, b:32'h0000FFFF, shamt:5'd0, op:4'd2, sign:1'b0, regwrite:1'b1, dest:5'd4, br:1'b0, ill:1'b0};
    n_cmp++; if (obs !== want) begin n_err++; $display("[TB] FAIL andi: got %h want %h", obs, want); end
    set_instr({6'h0F, 5'd0, 5'd5, 16'h1234});
    tick();
    want = '{valid:1'b1, a:32'h1234, b:32'h0, shamt:5'd16, op:4'd5, sign:1'b0, regwrite:1'b1, dest:5'd5, br:1'b0, ill:1'b0};
    n_cmp++; if (obs !== want) begin n_err++; $display("[TB] FAIL lui: got %h want %h", obs, want); end
  endtask

  task automatic test_shifts();
    ex_t want;
    rs_data = 32'h77; rt_data = 32'h8000_0001;
    set_instr({6'h00, 5'd1, 5'd2, 5'd8, 5'd4, 6'h00});
    tick();
    want = '{valid:1'b1, a:32'h8000_0001, b:32'h0, shamt:5'd4, op:4'd5, sign:1'b0, regwrite:1'b1, dest:5'd8, br:1'b0, ill:1'b0};
    n_cmp++; if (obs !== want) begin n_err++; $display("[TB] FAIL sll: got %h want %h", obs, want); end
    set_instr({6'h00, 5'd1, 5'd2, 5'd9, 5'd31, 6'h02});
    tick();
    want = '{valid:1'b1, a:32'h8000_0001, b:32'h0, shamt:5'd31, op:4'd6, sign:1'b0, regwrite:1'b1, dest:5'd9, br:1'b0, ill:1'b0};
    n_cmp++; if (obs !== want) begin n_err++; $display("[TB] FAIL srl: got %h want %h", obs, want); end
  endtask

  task automatic test_forwarding();
    set_instr({6'h00, 5'd7, 5'd2, 5'd3, 5'd0, 6'h20});
    rs_data = 32'h1111;
    exm_regwrite = 1'b1; exm_rd = 5'd7; exm_result = 32'hAAAA;
    wb_regwrite = 1'b1; wb_rd = 5'd7; wb_result = 32'hBBBB;
    tick();
    n_cmp++; if (ex_a !== 32'hAAAA) begin n_err++; $display("[TB] FAIL fwd_exm: got %h want 0000aaaa", ex_a); end
    exm_regwrite = 1'b0;
    tick();
    n_cmp++; if (ex_a !== 32'hBBBB) begin n_err++; $display("[TB] FAIL fwd_wb: got %h want 0000bbbb", ex_a); end
    set_instr({6'h00, 5'd0, 5'd2, 5'd3, 5'd0, 6'h20});
    exm_regwrite = 1'b1; exm_rd = 5'd0; wb_rd = 5'd0;
    tick();
    n_cmp++; if (ex_a !== 32'h1111) begin n_err++; $display("[TB] FAIL fwd_r0: got %h want 00001111", ex_a); end
    n_cmp++; if (obs !== exp_ex) begin n_err++; $display("[TB] FAIL fwd_r0_model: got %h want %h", obs, exp_ex); end
    no_fwd();
  endtask

  task automatic test_stall_flush();
    ex_t want;
    logic [31:0] cnt;
    set_instr({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h22});
    rs_data = 32'd9; rt_data = 32'd4;
    tick();
    cnt = exp_count;
    want = '{valid:1'b1, a:32'd9, b:32'd4, shamt:5'd0, op:4'd1, sign:1'b1, regwrite:1'b1, dest:5'd3, br:1'b0, ill:1'b0};
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_instr($urandom); rs_data = $urandom; rt_data = $urandom;
      tick();
      n_cmp++; if (obs !== want) begin n_err++; $display("[TB] FAIL stall_hold: got %h want %h", obs, want); end
      n_cmp++; if (issue_count !== cnt) begin n_err++; $display("[TB] FAIL stall_count: got %0d want %0d", issue_count, cnt); end
    end
    flush = 1'b1;
    tick();
    n_cmp++; if (obs !== '0) begin n_err++; $display("[TB] FAIL stall_flush: got %h want 0", obs); end
    n_cmp++; if (issue_count !== cnt) begin n_err++; $display("[TB] FAIL flush_count: got %0d want %0d", issue_count, cnt); end
    stall = 1'b0; flush = 1'b0;
  endtask

  task automatic test_illegal_and_bubble();
    ex_t want;
    logic [31:0] cnt;
    cnt = exp_count;
    set_instr({6'h3F, 5'd1, 5'd2, 16'h1234});
    rs_data = 32'hDEAD; rt_data = 32'hBEEF;
    tick();
    want = '{valid:1'b1, a:32'h0, b:32'h0, shamt:5'd0, op:4'd0, sign:1'b0, regwrite:1'b0, dest:5'd0, br:1'b0, ill:1'b1};
    n_cmp++; if (obs !== want) begin n_err++; $display("[TB] FAIL illegal: got %h want %h", obs, want); end
    n_cmp++; if (issue_count !== cnt + 32'd1) begin n_err++; $display("[TB] FAIL illegal_count: got %0d want %0d", issue_count, cnt + 32'd1); end
    in_valid = 1'b0;
    tick();
    n_cmp++; if (obs !== '0) begin n_err++; $display("[TB] FAIL bubble: got %h want 0", obs); end
    n_cmp++; if (issue_count !== cnt + 32'd1) begin n_err++; $display("[TB] FAIL bubble_count: got %0d want %0d", issue_count, cnt + 32'd1); end
    in_valid = 1'b1;
  endtask

  task automatic test_beq_sltu();
    ex_t want;
    set_instr({6'h04, 5'd1, 5'd2, 16'h0010});
    rs_data = 32'd7; rt_data = 32'd7;
    tick();
    want = '{valid:1'b1, a:32'd7, b:32'd7, shamt:5'd0, op:4'd1, sign:1'b0, regwrite:1'b0, dest:5'd0, br:1'b1, ill:1'b0};
    n_cmp++; if (obs !== want) begin n_err++; $display("[TB] FAIL beq: got %h want %h", obs, want); end
    set_instr({6'h00, 5'd1, 5'd2, 5'd6, 5'd0, 6'h2B});
    rs_data = 32'd3; rt_data = 32'hFFFFFFFF;
    tick();
    want = '{valid:1'b1, a:32'd3, b:32'hFFFFFFFF, shamt:5'd0, op:4'd7, sign:1'b0, regwrite:1'b1, dest:5'd6, br:1'b0, ill:1'b0};
    n_cmp++; if (obs !== want) begin n_err++; $display("[TB] FAIL sltu: got %h want %h", obs, want); end
  endtask

  task automatic test_random();
    logic [31:0] instr;
    int r;
    for (int n = 0; n < 300; n++) begin
      instr = $urandom;
      r = $urandom_range(0, 21);
      if (r < 19) begin
        instr[31:26] = rules[r].opc;
        if (rules[r].opc == 6'h00) instr[5:0] = rules[r].fn;
      end
      instr[25:21] = 5'($urandom_range(0, 7));
      instr[20:16] = 5'($urandom_range(0, 7));
      set_instr(instr);
      rs_data = $urandom; rt_data = $urandom;
      exm_regwrite = 1'($urandom_range(0, 1)); exm_rd = 5'($urandom_range(0, 7)); exm_result = $urandom;
      wb_regwrite = 1'($urandom_range(0, 1)); wb_rd = 5'($urandom_range(0, 7)); wb_result = $urandom;
      in_valid = ($urandom_range(0, 9) != 0);
      stall = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 9) == 0);
      tick();
      n_cmp++; if (obs !== exp_ex) begin n_err++; $display("[TB] FAIL random_fields[%0d]: got %h want %h", n, obs, exp_ex); end
      n_cmp++; if (issue_count !== exp_count) begin n_err++; $display("[TB] FAIL random_count[%0d]: got %0d want %0d", n, issue_count, exp_count); end
    end
    stall = 1'b0; flush = 1'b0; no_fwd();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    set_instr(32'd0); rs_data = 32'd0; rt_data = 32'd0; no_fwd();
    exp_ex = '0; exp_count = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_add();
    test_immediates();
    test_shifts();
    test_forwarding();
    test_stall_flush();
    test_illegal_and_bubble();
    test_beq_sltu();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
